// File: rtl/seq_fxp_div.sv
// rtl/seq_fxp_div.sv - iterative signed Q-format divider, one restoring quotient bit per clock
// Optional: define SEQ_FXP_DIV_ROUND_EN for round-half-away-from-zero (one extra CALC cycle).
module seq_fxp_div #(
  parameter int DATA_WIDTH = 16,
  parameter int BIN_POS    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quot,
  output logic                  dbz,
  output logic                  ovf
);
  localparam int QW = DATA_WIDTH + BIN_POS;
  localparam int CW = $clog2(QW + 1);
  localparam logic [QW-1:0]         NEG_MAG = {{(QW-1){1'b0}}, 1'b1} << (DATA_WIDTH - 1);
  localparam logic [QW-1:0]         POS_MAX = NEG_MAG - QW'(1);
  localparam logic [DATA_WIDTH-1:0] Q_MAX   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] Q_MIN   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  state_t r_state, w_state_nx;

  logic                  r_sign;
  logic [QW-1:0]         r_dvd;
  logic [DATA_WIDTH-1:0] r_dvs;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_quot;
  logic                  r_dbz;
  logic                  r_ovf;

  logic                  w_accept;
  logic                  w_bzero;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_a_mag;
  logic [DATA_WIDTH-1:0] w_b_mag;
  logic [DATA_WIDTH:0]   w_rem_sh;
  logic                  w_ge;
  logic [DATA_WIDTH-1:0] w_rem_nx;
  logic [QW-1:0]         w_qmag_nx;
  logic [QW-1:0]         w_qmag_fin;
  logic [DATA_WIDTH-1:0] w_quot_fin;
  logic                  w_ovf_fin;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_bzero  = (b == '0);
  // Read as unsigned: negating the most negative value gives 2^(DW-1), its exact magnitude.
  assign w_a_mag  = a[DATA_WIDTH-1] ? -a : a;
  assign w_b_mag  = b[DATA_WIDTH-1] ? -b : b;

  // The quotient bits shift into the dividend register as the dividend bits shift out.
  assign w_rem_sh  = {r_rem, r_dvd[QW-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_nx  = w_ge ? DATA_WIDTH'(w_rem_sh - {1'b0, r_dvs}) : w_rem_sh[DATA_WIDTH-1:0];
  assign w_qmag_nx = {r_dvd[QW-2:0], w_ge};

`ifdef SEQ_FXP_DIV_ROUND_EN
  logic w_rnd_up;
  assign w_rnd_up   = ({r_rem, 1'b0} >= {1'b0, r_dvs});
  assign w_qmag_fin = r_dvd + QW'(w_rnd_up);
  assign w_last     = (r_cnt == '0);
`else
  assign w_qmag_fin = w_qmag_nx;
  assign w_last     = (r_cnt == CW'(1));
`endif

  always_comb begin
    w_quot_fin = w_qmag_fin[DATA_WIDTH-1:0];
    w_ovf_fin  = 1'b0;
    if (r_sign) begin
      if (w_qmag_fin > NEG_MAG) begin
        w_quot_fin = Q_MIN;
        w_ovf_fin  = 1'b1;
      end else begin
        w_quot_fin = -w_qmag_fin[DATA_WIDTH-1:0];
      end
    end else if (w_qmag_fin > POS_MAX) begin
      w_quot_fin = Q_MAX;
      w_ovf_fin  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nx = w_bzero ? S_DONE : S_CALC;
      S_CALC:  if (w_last) w_state_nx = S_DONE;
      S_DONE:  if (out_ready) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_quot <= '0;
      r_dbz  <= 1'b0;
      r_ovf  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_accept) begin
        if (w_bzero) begin
          r_dbz  <= 1'b1;
          r_ovf  <= 1'b0;
          r_quot <= a[DATA_WIDTH-1] ? Q_MIN : Q_MAX;
        end else begin
          r_sign <= a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
          r_dvd  <= QW'(w_a_mag) << BIN_POS;
          r_dvs  <= w_b_mag;
          r_rem  <= '0;
          r_cnt  <= CW'(QW);
        end
      end
      if (r_state == S_CALC) begin
        if (r_cnt != '0) begin
          r_rem <= w_rem_nx;
          r_dvd <= w_qmag_nx;
          r_cnt <= r_cnt - CW'(1);
        end
        if (w_last) begin
          r_quot <= w_quot_fin;
          r_ovf  <= w_ovf_fin;
          r_dbz  <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign quot      = r_quot;
  assign dbz       = r_dbz;
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_seq_fxp_div.sv
// tb/tb_seq_fxp_div.sv - directed vectors with an arithmetic reference model for seq_fxp_div
`timescale 1ns/1ps
module tb_seq_fxp_div;
  localparam int DW = 16;
  localparam int BP = 8;
  localparam int QW = DW + BP;
`ifdef SEQ_FXP_DIV_ROUND_EN
  localparam int LAT = QW + 2;
`else
  localparam int LAT = QW + 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] quot;
  logic        dbz;
  logic        ovf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_fxp_div #(.DATA_WIDTH(DW), .BIN_POS(BP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .quot(quot), .dbz(dbz), .ovf(ovf)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] q;
    logic        d;
    logic        o;
    int          acc;
    int          lat;
  } exp_t;

  exp_t pend[$];
  logic [15:0] last_q = '0;
  logic        last_d = 1'b0;
  logic        last_o = 1'b0;
  logic        exp_rdy;
  logic        exp_ov;

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: exact integer ratio of the scaled dividend, then rounding and saturation.
  function automatic exp_t model(input logic [15:0] ia, input logic [15:0] ib, input int acc);
    exp_t   e;
    longint num, den, qq, rr;
    num   = longint'($signed(ia)) * (longint'(1) << BP);
    den   = longint'($signed(ib));
    e.acc = acc;
    if (den == 0) begin
      e.d   = 1'b1;
      e.o   = 1'b0;
      e.q   = ia[15] ? 16'h8000 : 16'h7FFF;
      e.lat = 1;
    end else begin
      qq    = num / den;
      rr    = num % den;
      e.d   = 1'b0;
      e.lat = LAT;
`ifdef SEQ_FXP_DIV_ROUND_EN
      if (2 * labs(rr) >= labs(den)) qq = ((num < 0) != (den < 0)) ? qq - 1 : qq + 1;
`endif
      if (qq > 32767) begin
        e.q = 16'h7FFF;
        e.o = 1'b1;
      end else if (qq < -32768) begin
        e.q = 16'h8000;
        e.o = 1'b1;
      end else begin
        e.q = 16'(qq);
        e.o = 1'b0;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      last_q = '0;
      last_d = 1'b0;
      last_o = 1'b0;
    end else begin
      exp_rdy = (pend.size() == 0);
      exp_ov  = !exp_rdy && ((cyc - pend[0].acc + 1) >= pend[0].lat);
      chk("m_in_ready", in_ready, exp_rdy);
      chk("m_out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        chk("m_quot", quot, pend[0].q);
        chk("m_dbz", dbz, pend[0].d);
        chk("m_ovf", ovf, pend[0].o);
      end else if (exp_rdy) begin
        chk("m_idle_quot", quot, last_q);
        chk("m_idle_dbz", dbz, last_d);
        chk("m_idle_ovf", ovf, last_o);
      end
      if (exp_rdy && in_valid) begin
        pend.push_back(model(a, b, cyc + 1));
      end else if (exp_ov && out_ready) begin
        last_q = pend[0].q;
        last_d = pend[0].d;
        last_o = pend[0].o;
        void'(pend.pop_front());
      end
    end
  end

  task automatic run(input logic [15:0] ta, input logic [15:0] tbv, input logic [15:0] eq,
                     input logic ed, input logic eo, input int el, input int hold, input string nm);
    int n;
    a = ta;
    b = tbv;
    in_valid = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, n, el);
    chk({nm, "_quot"}, quot, eq);
    chk({nm, "_dbz"}, dbz, ed);
    chk({nm, "_ovf"}, ovf, eo);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      a = 16'($urandom);
      b = 16'($urandom);
      @(posedge clk); #1;
      chk({nm, "_hold_quot"}, quot, eq);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_back_idle"}, in_ready, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_quot", quot, 0);
    chk("reset_flags", {dbz, ovf}, 0);

    run(16'h0300, 16'h0180, 16'h0200, 1'b0, 1'b0, LAT, 0, "q3_by_1p5");
`ifdef SEQ_FXP_DIV_ROUND_EN
    run(16'h0200, 16'h0300, 16'h00AB, 1'b0, 1'b0, LAT, 0, "q2_by_3");
    run(16'hFE00, 16'h0300, 16'hFF55, 1'b0, 1'b0, LAT, 0, "qm2_by_3");
`else
    run(16'h0200, 16'h0300, 16'h00AA, 1'b0, 1'b0, LAT, 0, "q2_by_3");
    run(16'hFE00, 16'h0300, 16'hFF56, 1'b0, 1'b0, LAT, 0, "qm2_by_3");
`endif
    run(16'h0100, 16'hFD00, 16'hFFAB, 1'b0, 1'b0, LAT, 0, "q1_by_m3");
    run(16'h0100, 16'h0000, 16'h7FFF, 1'b1, 1'b0, 1, 0, "dbz_pos");
    run(16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b0, 1, 0, "dbz_neg");
    run(16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b1, LAT, 0, "ovf_pos");
    run(16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0, LAT, 0, "exact_min");
    run(16'h8000, 16'hFF00, 16'h7FFF, 1'b0, 1'b1, LAT, 0, "ovf_min_by_m1");
    run(16'h0000, 16'h0300, 16'h0000, 1'b0, 1'b0, LAT, 0, "zero_dividend");
    run(16'h0500, 16'h0200, 16'h0280, 1'b0, 1'b0, LAT, 10, "backpressure");

    a = 16'h0300;
    b = 16'h0100;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_quot", quot, 0);
    chk("abort_flags", {dbz, ovf}, 0);
    run(16'h0400, 16'h0200, 16'h0200, 1'b0, 1'b0, LAT, 0, "after_abort");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_fxp_div.md
Name: seq_fxp_div

Overview:
Iterative signed fixed-point divider, the multi-cycle successor to the combinational divider. It computes quot = (a << BIN_POS) / b on Q-format operands, producing one quotient bit per clock, and is therefore synthesizable at full clock rate. It has valid/ready handshakes on input and output, saturation on overflow and divide-by-zero, and status flags. It sits wherever the navigation datapath needs a fixed-point ratio and can tolerate multi-cycle latency.

Parameters:
DATA_WIDTH, 16, operand and result width in bits (two's complement); legal range 4..32.
BIN_POS, 8, number of fractional bits in a, b and quot; legal range 0..DATA_WIDTH-1.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  operands a/b are valid.
in_ready  output  1  block can accept operands (high only in IDLE).
a  input  DATA_WIDTH  signed dividend.
b  input  DATA_WIDTH  signed divisor.
out_valid  output  1  quot and flags are valid.
out_ready  input  1  consumer accepts the result.
quot  output  DATA_WIDTH  signed quotient, same Q-format as the inputs.
dbz  output  1  divide-by-zero occurred (qualified by out_valid).
ovf  output  1  result saturated because of overflow (qualified by out_valid).

Behaviour:
- Define QW = DATA_WIDTH + BIN_POS, the number of quotient iterations.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - CALC: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Reset: while rst is high on a clock edge, the state goes to IDLE and quot, dbz, ovf, out_valid and the iteration counter are all cleared to 0. Reset mid-CALC or mid-DONE abandons the operation with no output.
- IDLE to CALC, on in_valid && in_ready:
  - Latch sign_q = a[MSB] ^ b[MSB].
  - Latch dividend magnitude |a| << BIN_POS into a QW-bit register.
  - Latch |b| into a DATA_WIDTH-bit register.
  - Clear the remainder (DATA_WIDTH+1 bits).
  - Load the counter with QW.
  - Magnitudes are computed at DATA_WIDTH+1 bits, so the most negative value is handled correctly.
- IDLE to DONE, on acceptance with b == 0: skip CALC. Set dbz=1 and ovf=0; quot = 2^(DATA_WIDTH-1)-1 if a >= 0, otherwise -2^(DATA_WIDTH-1).
- CALC performs one restoring step per cycle:
  - rem = (rem << 1) | dividend MSB; shift the dividend left by 1.
  - If rem >= |b|: rem -= |b| and shift in a quotient bit of 1; otherwise shift in 0.
  - Decrement the counter. When the counter reaches 0, go to DONE.
- Latency: out_valid rises exactly QW+1 rising edges after the accepting edge (25 edges for the defaults). Divide-by-zero gives 1 edge. Throughput is one result per QW+2 cycles minimum.
- Entry to DONE (from CALC), given the QW-bit magnitude result qmag:
  - Positive result: if qmag > 2^(DATA_WIDTH-1)-1, then quot = max positive and ovf=1.
  - Negative result: if qmag > 2^(DATA_WIDTH-1), then quot = most negative and ovf=1.
  - Otherwise quot = sign_q ? -qmag : qmag (truncation toward zero) and ovf=0.
  - dbz=0.
  - Zero dividend: quot = 0, never -0 issues.
- DONE: quot, dbz and ovf are held stable while out_valid=1 && out_ready=0. On out_ready=1 the block returns to IDLE on that edge and out_valid drops; quot and the flags keep their last values.
- in_valid asserted while in_ready=0 is ignored; the operands are not captured.
- Inputs are sampled only on the accepting edge; a and b may change freely afterwards.

Optional Feature:
SEQ_FXP_DIV_ROUND_EN:
- Defined: the block performs one extra cycle in CALC after the last quotient bit. If 2*rem >= |b|, qmag is incremented (round half away from zero) before saturation and sign are applied. Latency becomes QW+2 edges. ovf is also set if rounding pushes qmag past the limit.
- Undefined: truncation toward zero, latency QW+1.

Test Plan:
- a=0x0300 (3.0), b=0x0180 (1.5) -> quot=0x0200, dbz=0, ovf=0, out_valid exactly 25 edges after acceptance.
- a=0x0200 (2.0), b=0x0300 (3.0) -> quot=0x00AA truncated; with SEQ_FXP_DIV_ROUND_EN, 0x00AB at 26 edges. a=0xFE00, b=0x0300 -> 0xFF56 truncated / 0xFF55 rounded.
- a=0x0100, b=0x0000 -> quot=0x7FFF, dbz=1, out_valid 1 edge after acceptance. a=0x8000, b=0 -> quot=0x8000, dbz=1.
- a=0x7FFF, b=0x0001 -> quot=0x7FFF, ovf=1. a=0x8000, b=0x0100 -> quot=0x8000, ovf=0 (exact most-negative). a=0x8000, b=0xFF00 -> quot=0x7FFF, ovf=1.
- Backpressure: out_ready held low for 10 cycles in DONE -> quot and flags stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> IDLE next edge and a new operand pair is accepted.
- rst asserted at iteration 10 of CALC -> next cycle in IDLE with all outputs 0. The following division 0x0400/0x0200 returns 0x0200 with no residue from the aborted operation.
